// File: rtl/nibble_uart_tx.sv
// Nibble-link serial transmitter: start bit, 4 data bits LSB first, optional even parity, stop bit.
// Define NIBBLE_UART_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module nibble_uart_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef NIBBLE_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       shreg_q, shreg_d;
    logic             tx_out_q, tx_out_d;
    logic             tx_done_q, tx_done_d;
    logic             bit_end;
`ifdef NIBBLE_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        tx_done_d = 1'b0;
`ifdef NIBBLE_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = 2'd0;
                if (tx_valid) begin
                    shreg_d = tx_data;
`ifdef NIBBLE_UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[3:1]};
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
`ifdef NIBBLE_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
`ifdef NIBBLE_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d   = S_IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is looked up from the next state so tx_out stays a flop output.
        case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shreg_d[0];
`ifdef NIBBLE_UART_TX_PARITY_EN
            S_PARITY: tx_out_d = par_d;
`endif
            default:  tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shreg_q   <= 4'd0;
            tx_out_q  <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef NIBBLE_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
`ifdef NIBBLE_UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_out   = tx_out_q;
    assign tx_done  = tx_done_q;

endmodule
